mem_stage_dmem_ctrl: RTL and testbench
======================================

Name: mem_stage_dmem_ctrl

Overview:
- Memory-side endpoint for the EX/MEM pipeline register's data-memory request: it consumes mem_read, mem_write, mem_wdata, the address and funct3.
- Runs each request as a held req/resp transaction on the data-memory bus, with store byte-lane formatting and load extraction/sign-extension.
- Stalls the pipeline until the access completes.
- Flags misaligned accesses and bus timeouts.

Parameters:
- MAX_WAIT, default 255: cycles allowed in ACCESS without dmem_resp before timeout; 0 disables the timeout.
- CNT_W, default 8: wait-counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- mem_addr  in  32  byte address (EX/MEM alu_out).
- mem_wdata  in  32  unshifted store data (rs2).
- funct3  in  3  load/store width and sign (control_word.funct3).
- stall  out  1  hold all pipeline register loads.
- load_data  out  32  formatted load result, valid in DONE.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  with done: access was misaligned and not issued.
- timeout  out  1  with done: bus did not respond within MAX_WAIT.
- dmem_read  out  1  bus read strobe.
- dmem_write  out  1  bus write strobe.
- dmem_address  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_byte_enable  out  4  store lane mask; 4'b1111 on reads.
- dmem_rdata  in  32  bus read data.
- dmem_resp  in  1  bus completion, single cycle.

Behaviour:
- **Reset** (rst=0, asynchronous): state=IDLE. All outputs are 0, dmem strobes drop immediately, counter=0, captured request cleared.
- **IDLE**:
  - If mem_read or mem_write, capture addr/wdata/funct3/type; stall=1 combinationally in the same cycle.
  - If both are asserted, the write wins.
  - Aligned request -> ACCESS. Misaligned request -> DONE with misalign=1.
  - Misaligned means: half access with addr[0]=1, or word access with addr[1:0]!=0.
- **ACCESS**:
  - Strobe and address/data/byte-enable are registered outputs, stable until resp.
  - stall=1 and the counter increments each cycle.
  - dmem_resp=1 -> latch formatted dmem_rdata (loads) and go to DONE.
  - If counter==MAX_WAIT-1 with no resp and MAX_WAIT!=0: drop strobes, go to DONE with timeout=1 and load_data=0.
- **DONE**:
  - done=1 and stall=0; the pipeline advances on this edge.
  - Inputs are ignored because they still show the completed instruction. Next state is IDLE.
- **Latency**: request seen at cycle 0, strobe from cycle 1, resp at cycle k>=1, done at k+1. Minimum 3 cycles per access.
- **Store formatting**:
  - sb: be=4'b0001<<addr[1:0], wdata byte replicated to all lanes.
  - sh: be=4'b0011<<{addr[1],1'b0}, halfword replicated.
  - sw: be=4'b1111.
- **Load formatting**:
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1]; lw takes the whole word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - An unknown funct3 is treated as word.
- load_data holds its last value outside DONE. It is 0 on stores, misalign and timeout.
- A resp arriving in IDLE or DONE is ignored.

Decomposition:
- rv32i_types: add dmem_state_t (IDLE, ACCESS, DONE).
- Reuse load_funct3_t/store_funct3_t from the shared package.
- Sub-module dmem_align (combinational): byte-enable/wdata shifting and load extraction, shared with a future instruction-fetch path.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, resp at 2nd ACCESS cycle -> dmem_write=1, be=1111, address=0x100, done at cycle 3, stall high for cycles 0-2.
- lb addr=0x203, rdata=0x80AABBCC -> load_data=0xFFFFFF80; lbu same -> 0x00000080; lh addr=0x202 -> 0xFFFF80AA.
- sh addr=0x301 -> no dmem strobe ever; done+misalign at cycle 1; stall only at cycle 0.
- MAX_WAIT=4, lw with no resp -> strobe for 4 cycles, then done+timeout, load_data=0; a later resp is ignored.
- rst pulsed low mid-ACCESS -> strobes/stall drop asynchronously; after release an idle bus and a fresh sb addr=0x2, wdata=0x55 -> be=0100, wdata=0x55555555.
- sw then immediate lw to the same address (back-to-back) -> two separate transactions, second strobe starts the cycle after IDLE, no overlap of dmem_read/dmem_write.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I encodings plus the data-memory controller state type
package rv32i_types;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dmem_state_t;

    // funct3[1:0] encodes the access width; anything other than byte/half is a word
    localparam logic [1:0] WID_B = 2'(SB);
    localparam logic [1:0] WID_H = 2'(SH);

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        return (width == WID_H) ? addr_lo[0] : (width[1] ? |addr_lo : 1'b0);
    endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: store lane placement and load field extraction with sign/zero extension
module dmem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);
    logic       is_b;
    logic       is_h;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Decode width, replicate store data across lanes and extract/extend the load field
    always_comb begin
        is_b        = funct3[1:0] == WID_B;
        is_h        = funct3[1:0] == WID_H;
        rbyte       = 8'(rdata >> {addr_lo, 3'b000});
        rhalf       = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_enable = is_b ? 4'b0001 << addr_lo
                    : is_h ? 4'b0011 << {addr_lo[1], 1'b0}
                    : 4'b1111;
        wdata_lanes = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
        load_data   = is_b ? {{24{~funct3[2] & rbyte[7]}}, rbyte}
                    : is_h ? {{16{~funct3[2] & rhalf[15]}}, rhalf}
                    : rdata;
    end
endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// mem_stage_dmem_ctrl: runs the MEM-stage load/store as a held req/resp bus transaction
module mem_stage_dmem_ctrl
    import rv32i_types::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misalign,
    output logic        timeout,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       ld_q, ld_d;
    logic              mis_q, mis_d;
    logic              to_q, to_d;
    logic              req;
    logic              bad;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata;
    logic [31:0]       fmt_ld;

    // Formatting works from the captured request so bus outputs stay stable through ACCESS
    dmem_align u_align (
        .funct3      (f3_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (dmem_rdata),
        .byte_enable (fmt_be),
        .wdata_lanes (fmt_wdata),
        .load_data   (fmt_ld)
    );

    assign req = mem_read | mem_write;
    assign bad = misaligned(funct3[1:0], mem_addr[1:0]);

    // Next-state: capture in IDLE, wait for resp or timeout in ACCESS, one-cycle DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ld_d    = ld_q;
        mis_d   = mis_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = mem_addr;
                wdata_d = mem_wdata;
                f3_d    = funct3;
                cnt_d   = '0;
                rd_d    = !bad && !mem_write;
                wr_d    = !bad && mem_write;
                mis_d   = bad;
                to_d    = 1'b0;
                ld_d    = bad ? 32'h0 : ld_q;
                state_d = bad ? DONE : ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_resp) begin
                    ld_d    = wr_q ? 32'h0 : fmt_ld;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else if (MAX_WAIT != 0 && cnt_q == LAST) begin
                    ld_d    = 32'h0;
                    to_d    = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                cnt_d   = '0;
                mis_d   = 1'b0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    // Stall is combinational in IDLE so the requesting instruction holds in the same cycle
    assign stall            = rst & ((state_q == ACCESS) | ((state_q == IDLE) & req));
    assign done             = state_q == DONE;
    assign misalign         = mis_q;
    assign timeout          = to_q;
    assign load_data        = ld_q;
    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = {addr_q[31:2], 2'b00};
    assign dmem_wdata       = fmt_wdata;
    assign dmem_byte_enable = rd_q ? 4'b1111 : wr_q ? fmt_be : 4'b0000;
endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// tb_mem_stage_dmem_ctrl: directed scoreboard bench for the data-memory controller
module tb_mem_stage_dmem_ctrl;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  funct3;
    logic        stall, done, misalign, timeout;
    logic [31:0] load_data;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        to;
        int          lat;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    mem_stage_dmem_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .funct3           (funct3),
        .stall            (stall),
        .load_data        (load_data),
        .done             (done),
        .misalign         (misalign),
        .timeout          (timeout),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = exp_q.pop_front();
                chk("load_data", load_data, e.ld);
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("timeout", 32'(timeout), 32'(e.to));
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    // Issue one request (called just after a rising edge), answer it at ACCESS cycle k (0 = never)
    task automatic xact(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] rdata, input int k,
                        input logic [31:0] ld, input logic mis, input logic to, input int lat,
                        input logic [3:0] be, input logic [31:0] bw);
        exp_t e;
        bit   seen = 1'b0;
        mem_read   = rd;
        mem_write  = wr;
        mem_addr   = addr;
        mem_wdata  = wdata;
        funct3     = f3;
        dmem_rdata = rdata;
        dmem_resp  = 1'b0;
        e.ld = ld; e.mis = mis; e.to = to; e.lat = lat; e.issue = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        chk("stall_req", 32'(stall), 32'd1);
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(posedge clk);
            #1;
            dmem_resp = (k != 0) && (c == k);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("stall_done", 32'(stall), 32'd0);
                chk("strobe_done", 32'({dmem_read, dmem_write}), 32'd0);
            end else begin
                chk("stall_wait", 32'(stall), 32'd1);
                chk("rd_strobe", 32'(dmem_read), 32'(!mis && rd && !wr));
                chk("wr_strobe", 32'(dmem_write), 32'(!mis && wr));
                if (c == 1 && !mis) begin
                    chk("address", dmem_address, {addr[31:2], 2'b00});
                    chk("byte_en", 32'(dmem_byte_enable), 32'(wr ? be : 4'b1111));
                    if (wr) chk("wdata", dmem_wdata, bw);
                end
            end
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_wait: got no done within 12 cycles expected done");
        end
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dmem_resp = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        funct3 = '0; dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobes", 32'({dmem_read, dmem_write}), 32'd0);
        chk("rst_be", 32'(dmem_byte_enable), 32'd0);
        chk("rst_load", load_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        // store word, resp on second ACCESS cycle
        xact(0, 1, 32'h100, 32'hDEADBEEF, SW, 32'h0, 2, 32'h0, 0, 0, 3, 4'b1111, 32'hDEADBEEF);
        idle();
        // load byte/half variants
        xact(1, 0, 32'h203, 32'h0, LB,  32'h80AABBCC, 1, 32'hFFFFFF80, 0, 0, 2, 4'b1111, 32'h0);
        xact(1, 0, 32'h203, 32'h0, LBU, 32'h80AABBCC, 1, 32'h00000080, 0, 0, 2, 4'b1111, 32'h0);
        xact(1, 0, 32'h202, 32'h0, LH,  32'h80AABBCC, 1, 32'hFFFF80AA, 0, 0, 2, 4'b1111, 32'h0);
        xact(1, 0, 32'h200, 32'h0, LHU, 32'h80AABBCC, 1, 32'h0000BBCC, 0, 0, 2, 4'b1111, 32'h0);
        xact(1, 0, 32'h204, 32'h0, LW,  32'h12345678, 3, 32'h12345678, 0, 0, 4, 4'b1111, 32'h0);
        idle();
        // misaligned half store and word load
        xact(0, 1, 32'h301, 32'h1234, SH, 32'h0, 0, 32'h0, 1, 0, 1, 4'b0000, 32'h0);
        xact(1, 0, 32'h102, 32'h0, LW, 32'hFFFFFFFF, 0, 32'h0, 1, 0, 1, 4'b0000, 32'h0);
        idle();
        // both strobes requested: write wins
        xact(1, 1, 32'h306, 32'hA5A5BEEF, SH, 32'h0, 1, 32'h0, 0, 0, 2, 4'b1100, 32'hBEEFBEEF);
        idle();
        // no response: timeout after MAX_WAIT cycles, then a stray resp is ignored
        xact(1, 0, 32'h400, 32'h0, LW, 32'hCAFEF00D, 0, 32'h0, 0, 1, 5, 4'b1111, 32'h0);
        mem_read  = 1'b0;
        dmem_resp = 1'b1;
        @(negedge clk);
        chk("stray_resp_done", 32'(done), 32'd0);
        chk("stray_resp_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("stray_resp_after", 32'({done, dmem_read, dmem_write}), 32'd0);
        @(posedge clk);
        #1;
        // asynchronous reset in the middle of ACCESS
        mem_read = 1'b1; funct3 = LW; mem_addr = 32'h600;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_read", 32'(dmem_read), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_read", 32'(dmem_read), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_addr", dmem_address, 32'h0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({done, dmem_read, dmem_write, stall}), 32'd0);
        @(posedge clk);
        #1;
        xact(0, 1, 32'h2, 32'h55, SB, 32'h0, 1, 32'h0, 0, 0, 2, 4'b0100, 32'h55555555);
        // back-to-back store then load to the same word
        xact(0, 1, 32'h500, 32'h11223344, SW, 32'h0, 1, 32'h0, 0, 0, 2, 4'b1111, 32'h11223344);
        xact(1, 0, 32'h500, 32'h0, LW, 32'h11223344, 1, 32'h11223344, 0, 0, 2, 4'b1111, 32'h0);
        idle();
        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
